// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: examines operands MSB-first in CHUNK-bit slices,
// stops at the first differing slice and reports registered aeqb/agtb/altb flags.
module seq_magnitude_comparator #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             signed_mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             aeqb_o,
  output logic             agtb_o,
  output logic             altb_o
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IdxW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NCHUNK - 1);

  typedef enum logic [0:0] {StIdle, StCompare} state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             done_q, done_d;
  logic             aeqb_q, aeqb_d;
  logic             agtb_q, agtb_d;
  logic             altb_q, altb_d;

  logic [WIDTH-1:0] a_shift, b_shift;
  logic [CHUNK-1:0] a_slice, b_slice;

  // Shift the current slice up to the MSB end so a constant part-select picks it out.
  always_comb begin
    a_shift = a_q << (32'(idx_q) * CHUNK);
    b_shift = b_q << (32'(idx_q) * CHUNK);
    a_slice = a_shift[WIDTH-1 -: CHUNK];
    b_slice = b_shift[WIDTH-1 -: CHUNK];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    done_d  = 1'b0;
    aeqb_d  = aeqb_q;
    agtb_d  = agtb_q;
    altb_d  = altb_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          // Flipping the sign bit maps two's-complement order onto unsigned order.
          a_d            = a_i;
          b_d            = b_i;
          a_d[WIDTH-1]   = a_i[WIDTH-1] ^ signed_mode_i;
          b_d[WIDTH-1]   = b_i[WIDTH-1] ^ signed_mode_i;
          idx_d          = '0;
          state_d        = StCompare;
        end
      end
      StCompare: begin
        if (a_slice != b_slice) begin
          aeqb_d  = 1'b0;
          agtb_d  = (a_slice > b_slice);
          altb_d  = (a_slice < b_slice);
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (idx_q == LastIdx) begin
          aeqb_d  = 1'b1;
          agtb_d  = 1'b0;
          altb_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      done_q  <= 1'b0;
      aeqb_q  <= 1'b0;
      agtb_q  <= 1'b0;
      altb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      done_q  <= done_d;
      aeqb_q  <= aeqb_d;
      agtb_q  <= agtb_d;
      altb_q  <= altb_d;
    end
  end

  assign busy_o = (state_q == StCompare);
  assign done_o = done_q;
  assign aeqb_o = aeqb_q;
  assign agtb_o = agtb_q;
  assign altb_o = altb_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed bench for seq_magnitude_comparator (WIDTH=8, CHUNK=2) with hand-computed results.
module tb_seq_magnitude_comparator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       signed_mode;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic       aeqb;
  logic       agtb;
  logic       altb;

  int n_vec = 0;
  int n_err = 0;

  seq_magnitude_comparator #(
    .WIDTH(8),
    .CHUNK(2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .signed_mode_i(signed_mode),
    .a_i          (a),
    .b_i          (b),
    .busy_o       (busy),
    .done_o       (done),
    .aeqb_o       (aeqb),
    .agtb_o       (agtb),
    .altb_o       (altb)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Flags packed as {aeqb, agtb, altb}.
  task automatic check_outs(input string tag, input logic b_exp, input logic d_exp,
                            input logic [2:0] f_exp);
    check_eq({tag, ".busy"}, 32'(busy), 32'(b_exp));
    check_eq({tag, ".done"}, 32'(done), 32'(d_exp));
    check_eq({tag, ".flags"}, 32'({aeqb, agtb, altb}), 32'(f_exp));
  endtask

  // Called at a negedge; lat = cycles from accept edge to done edge.
  task automatic run_cmp(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic sm, input int lat, input logic [2:0] exp_f,
                         input logic [2:0] prev_f, input bit disturb);
    start       = 1'b1;
    a           = av;
    b           = bv;
    signed_mode = sm;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < lat; j++) begin
      check_outs($sformatf("%s.wait%0d", tag, j), 1'b1, 1'b0, prev_f);
      if (disturb) begin
        start = (j == 1);
        if (j == 1) begin
          a           = 8'hFF;
          signed_mode = ~sm;
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
    start = 1'b0;
    check_outs({tag, ".done"}, 1'b0, 1'b1, exp_f);
    @(posedge clk);
    @(negedge clk);
    check_outs({tag, ".after"}, 1'b0, 1'b0, exp_f);
  endtask

  initial begin
    rst_n       = 1'b1;
    start       = 1'b0;
    signed_mode = 1'b0;
    a           = 8'h00;
    b           = 8'h00;

    // 1: async reset with random inputs, then idle
    #2;
    rst_n       = 1'b0;
    start       = 1'($urandom);
    signed_mode = 1'($urandom);
    a           = 8'($urandom);
    b           = 8'($urandom);
    #1;
    check_outs("rst_async", 1'b0, 1'b0, 3'b000);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_outs($sformatf("idle%0d", i), 1'b0, 1'b0, 3'b000);
    end

    // 2: MSB slice 10 vs 00
    run_cmp("gt_msb", 8'hA5, 8'h25, 1'b0, 1, 3'b010, 3'b000, 1'b0);
    // 3: all slices equal
    run_cmp("eq", 8'h3C, 8'h3C, 1'b0, 4, 3'b100, 3'b010, 1'b0);
    // 4: sign-sensitive operands
    run_cmp("signed", 8'h80, 8'h7F, 1'b1, 1, 3'b001, 3'b100, 1'b0);
    run_cmp("unsigned", 8'h80, 8'h7F, 1'b0, 1, 3'b010, 3'b001, 1'b0);
    // 5: difference only in the last slice, inputs disturbed while busy
    run_cmp("lt_lsb", 8'h12, 8'h13, 1'b0, 4, 3'b001, 3'b010, 1'b1);

    // 6: reset mid-compare
    start       = 1'b1;
    a           = 8'h3C;
    b           = 8'h3C;
    signed_mode = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check_outs("abort.busy", 1'b1, 1'b0, 3'b001);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("abort.rst", 1'b0, 1'b0, 3'b000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_outs($sformatf("abort.hold%0d", i), 1'b0, 1'b0, 3'b000);
    end
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_outs("abort.rel", 1'b0, 1'b0, 3'b000);
    run_cmp("restart", 8'h01, 8'h00, 1'b0, 4, 3'b010, 3'b000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_magnitude_comparator.md
# seq_magnitude_comparator

Parametrised, multi-cycle magnitude comparator that generalises the team's 4-bit combinational `aeqb`/`agtb`/`altb` comparator. It handles any operand width, supports signed (two's-complement) and unsigned modes selected per request, and processes operands MSB-first in `CHUNK`-bit slices with early exit on the first differing slice. It sits between a requester and the datapath flag logic, using a start/busy/done handshake and registered result flags.

## Interface

- `WIDTH`, 8, operand width in bits; must be a multiple of `CHUNK`.
- `CHUNK`, 2, bits examined per cycle; `NCHUNK = WIDTH/CHUNK` ≥ 1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `signed_mode`  in  1  1 = two's-complement compare, 0 = unsigned; latched with operands.
- `a`  in  WIDTH  operand A; latched on accept.
- `b`  in  WIDTH  operand B; latched on accept.
- `busy`  out  1  high while in COMPARE.
- `done`  out  1  one-cycle pulse when a result is written.
- `aeqb`  out  1  A == B (registered).
- `agtb`  out  1  A > B (registered).
- `altb`  out  1  A < B (registered).

## Operation

- States: IDLE, COMPARE. Reset → IDLE.
- Reset values: `busy`=0, `done`=0, `aeqb`=0, `agtb`=0, `altb`=0; chunk index = 0; latched operands = 0.
- Accept: in IDLE with `start`=1 at an edge, latch `a`, `b`, `signed_mode`; set index = 0 (MSB slice); go to COMPARE; `busy`=1.
- Signed handling: at latch, if `signed_mode`=1, invert bit WIDTH-1 of both latched operands (offset-binary). All later comparison is unsigned on the latched values.
- COMPARE, each cycle: compare slice `index` (bits `[WIDTH-1-index*CHUNK -: CHUNK]`) of the latched A and B.
  - Slices differ: write `agtb`/`altb` from the slice result, write `aeqb`=0, then go to IDLE with `done`=1.
  - Slices equal and index < NCHUNK-1: increment index and stay in COMPARE.
  - Slices equal and index = NCHUNK-1: write `aeqb`=1, `agtb`=`altb`=0, then go to IDLE with `done`=1.
- After the first completed compare, exactly one flag is high. Flags hold until the next `done`. They are not cleared on accept.
- `start` while busy: ignored, not queued. Changes to `a`/`b`/`signed_mode` while busy have no effect.
- `done` deasserts on the next edge unconditionally.
- Reset mid-operation: async clear of all state and outputs; the in-flight compare is discarded and no `done` is produced.

## Timing

- Accept edge E0. Slice k is first to differ, or k = NCHUNK-1 if all slices are equal.
- At edge E(k+1): flags update, `done`=1, `busy`=0.
- Latency is 1 to NCHUNK cycles.
- `busy` is high from E0 to E(k+1).
- During the `done` cycle the FSM is in IDLE, so `start` held high is accepted at E(k+2). Back-to-back throughput is one compare per k+2 cycles.
- `rst_n` low forces outputs to reset values without waiting for `clk`. Release is synchronous to the next edge.

## Test plan

All scenarios use `WIDTH`=8, `CHUNK`=2 (NCHUNK=4).

1. Assert `rst_n`=0 with random inputs → `busy`=`done`=`aeqb`=`agtb`=`altb`=0 immediately. After release with `start`=0 for 5 cycles, all stay 0.
2. Unsigned, `a`=0xA5, `b`=0x25, start → MSB slice differs; `done` one cycle after accept with `agtb`=1, `aeqb`=`altb`=0.
3. Unsigned, `a`=`b`=0x3C → `busy` high for 4 cycles; `done` at E4 with `aeqb`=1.
4. `a`=0x80, `b`=0x7F. With `signed_mode`=1 → `altb`=1 after 1 cycle. Repeat with `signed_mode`=0 → `agtb`=1 after 1 cycle.
5. Unsigned, `a`=0x12, `b`=0x13 → `done` at E4 with `altb`=1. While busy, pulse `start` and change `a` to 0xFF → ignored; the result is still `altb`. The prior flags hold until E4.
6. Start `a`=0x3C, `b`=0x3C, then drop `rst_n` two cycles after accept → outputs clear asynchronously and no `done` appears. Restart with `a`=0x01, `b`=0x00 → `agtb` at E4.
